// File: rtl/pipe_stage_chain.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_chain
//  Description : In-order pipeline register chain with load-use stall,
//                flush/halt control, forward-select generation and
//                saturating stall/flush event counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_chain #(
    parameter int STAGES     = 4,
    parameter int PAYLOAD_W  = 64,
    parameter int RF_ADDRESS = 5,
    parameter int CNT_W      = 16,
    localparam int FWD_W     = $clog2(STAGES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [PAYLOAD_W-1:0]  in_payload,
    input  logic [RF_ADDRESS-1:0] in_rd,
    input  logic [RF_ADDRESS-1:0] in_rs1,
    input  logic [RF_ADDRESS-1:0] in_rs2,
    input  logic                  in_regwrite,
    input  logic                  in_memread,
    input  logic                  flush,
    input  logic                  halt,
    output logic                  in_ready,
    output logic                  stall,
    output logic                  out_valid,
    output logic [PAYLOAD_W-1:0]  out_payload,
    output logic [RF_ADDRESS-1:0] out_rd,
    output logic                  out_regwrite,
    output logic [FWD_W-1:0]      fwd_a_sel,
    output logic [FWD_W-1:0]      fwd_b_sel,
    output logic [STAGES-1:0]     stage_valid,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    typedef struct packed {
        logic                  valid;
        logic [PAYLOAD_W-1:0]  payload;
        logic [RF_ADDRESS-1:0] rd;
        logic [RF_ADDRESS-1:0] rs1;
        logic [RF_ADDRESS-1:0] rs2;
        logic                  regwrite;
        logic                  memread;
    } stage_t;

    stage_t           r_stage [STAGES];
    stage_t           w_incoming;
    logic             w_accept;
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_flush_count;

    // Load in stage0 whose result the incoming entry needs; x0 never counts.
    assign stall = in_valid
                 & r_stage[0].valid
                 & r_stage[0].memread
                 & r_stage[0].regwrite
                 & (r_stage[0].rd != '0)
                 & ((in_rs1 == r_stage[0].rd) | (in_rs2 == r_stage[0].rd));

    assign in_ready = ~stall & ~halt & ~flush & reset;
    assign w_accept = in_valid & in_ready;

    always_comb begin
        w_incoming          = '0;
        w_incoming.valid    = 1'b1;
        w_incoming.payload  = in_payload;
        w_incoming.rd       = in_rd;
        w_incoming.rs1      = in_rs1;
        w_incoming.rs2      = in_rs2;
        w_incoming.regwrite = in_regwrite;
        w_incoming.memread  = in_memread;
    end

    // Flush kills the entry leaving stage0 as well as the incoming one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < STAGES; k++) begin
                r_stage[k] <= '0;
            end
        end else if (!halt) begin
            r_stage[0] <= w_accept ? w_incoming : '0;
            r_stage[1] <= flush ? '0 : r_stage[0];
            for (int k = 2; k < STAGES; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else if (!halt) begin
            if (stall && !flush && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + c_cnt_one;
            end
            if (flush && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + c_cnt_one;
            end
        end
    end

    // Walk oldest to youngest so the youngest matching producer wins.
    always_comb begin
        fwd_a_sel = '0;
        fwd_b_sel = '0;
        for (int k = STAGES - 1; k >= 1; k--) begin
            if (r_stage[0].valid && r_stage[k].valid && r_stage[k].regwrite
                && (r_stage[k].rd != '0)) begin
                if (r_stage[k].rd == r_stage[0].rs1) begin
                    fwd_a_sel = FWD_W'(k);
                end
                if (r_stage[k].rd == r_stage[0].rs2) begin
                    fwd_b_sel = FWD_W'(k);
                end
            end
        end
    end

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_valid
            assign stage_valid[k] = r_stage[k].valid;
        end
    endgenerate

    assign out_valid    = r_stage[STAGES-1].valid;
    assign out_payload  = r_stage[STAGES-1].payload;
    assign out_rd       = r_stage[STAGES-1].rd;
    assign out_regwrite = r_stage[STAGES-1].valid & r_stage[STAGES-1].regwrite;
    assign stall_count  = r_stall_count;
    assign flush_count  = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_chain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_chain
//  Description : Directed scoreboard bench for pipe_stage_chain.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_chain;

    localparam int S  = 4;
    localparam int PW = 64;
    localparam int RA = 5;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [PW-1:0] in_payload;
    logic [RA-1:0] in_rd, in_rs1, in_rs2;
    logic          in_regwrite, in_memread, flush, halt;
    logic          in_ready, stall, out_valid, out_regwrite;
    logic [PW-1:0] out_payload;
    logic [RA-1:0] out_rd;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic [S-1:0]  stage_valid;
    logic [CW-1:0] stall_count, flush_count;

    // Narrow-counter instance: continuous load-use hazard to reach saturation.
    logic          s_reset;
    logic          s_in_ready, s_stall, s_out_valid, s_out_regwrite;
    logic [7:0]    s_out_payload;
    logic [RA-1:0] s_out_rd;
    logic [1:0]    s_fwd_a_sel, s_fwd_b_sel;
    logic [S-1:0]  s_stage_valid;
    logic [7:0]    s_stall_count, s_flush_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [PW-1:0] payload;
        logic [RA-1:0] rd;
        logic          rw;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    pipe_stage_chain #(.STAGES(S), .PAYLOAD_W(PW), .RF_ADDRESS(RA), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_payload(in_payload),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_regwrite(in_regwrite),
        .in_memread(in_memread), .flush(flush), .halt(halt), .in_ready(in_ready),
        .stall(stall), .out_valid(out_valid), .out_payload(out_payload),
        .out_rd(out_rd), .out_regwrite(out_regwrite), .fwd_a_sel(fwd_a_sel),
        .fwd_b_sel(fwd_b_sel), .stage_valid(stage_valid),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    pipe_stage_chain #(.STAGES(S), .PAYLOAD_W(8), .RF_ADDRESS(RA), .CNT_W(8)) u_sat (
        .clk(clk), .reset(s_reset), .in_valid(1'b1), .in_payload(8'hA5),
        .in_rd(5'd5), .in_rs1(5'd5), .in_rs2(5'd0), .in_regwrite(1'b1),
        .in_memread(1'b1), .flush(1'b0), .halt(1'b0), .in_ready(s_in_ready),
        .stall(s_stall), .out_valid(s_out_valid), .out_payload(s_out_payload),
        .out_rd(s_out_rd), .out_regwrite(s_out_regwrite), .fwd_a_sel(s_fwd_a_sel),
        .fwd_b_sel(s_fwd_b_sel), .stage_valid(s_stage_valid),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [PW-1:0] p, input logic [RA-1:0] rd,
                         input logic [RA-1:0] rs1, input logic [RA-1:0] rs2,
                         input logic rw, input logic mr);
        in_valid = v; in_payload = p; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_regwrite = rw; in_memread = mr;
    endtask

    task automatic push(input logic [PW-1:0] p, input logic [RA-1:0] rd, input logic rw);
        exp_t e;
        e.payload = p; e.rd = rd; e.rw = rw;
        sb.push_back(e);
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    // ALU entry that is accepted and survives to the output.
    task automatic alu(input logic [PW-1:0] p, input logic [RA-1:0] rd,
                       input logic [RA-1:0] rs1, input logic [RA-1:0] rs2);
        drive(1'b1, p, rd, rs1, rs2, 1'b1, 1'b0);
        push(p, rd, 1'b1);
        tick();
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got payload %0h expected no output", out_payload);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({out_payload, out_rd, out_regwrite} !== {e.payload, e.rd, e.rw}) begin
                    errors++;
                    $display("FAIL sb_out got %0h/%0d/%0b expected %0h/%0d/%0b",
                             out_payload, out_rd, out_regwrite, e.payload, e.rd, e.rw);
                end
            end
        end
    end

    initial begin
        reset = 1'b0; s_reset = 1'b0; flush = 1'b0; halt = 1'b0;
        idle();
        repeat (2) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_stage_valid", stage_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_fwd", {fwd_a_sel, fwd_b_sel}, 0);
        chk("rst_counters", {stall_count, flush_count}, 0);
        reset = 1'b1;

        // Back-to-back stream, no hazards
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 64'(i), 5'(i + 10), '0, '0, 1'b1, 1'b0);
            push(64'(i), 5'(i + 10), 1'b1);
            @(negedge clk);
            chk("stream_in_ready", in_ready, 1);
            tick();
            if (i == 3) chk("lat_not_yet", out_valid, 0);
            if (i == 4) chk("lat_first_out", {out_valid, out_payload}, {1'b1, 64'd1});
        end
        idle();
        repeat (4) tick();

        // Load-use stall
        drive(1'b1, 64'h100, 5'd5, '0, '0, 1'b1, 1'b1);
        push(64'h100, 5'd5, 1'b1);
        tick();
        drive(1'b1, 64'h101, 5'd6, 5'd5, '0, 1'b1, 1'b0);
        @(negedge clk);
        chk("lu_stall", {stall, in_ready}, 2'b10);
        tick();
        chk("lu_stage_valid", stage_valid, 4'b0010);
        chk("lu_stall_count", stall_count, 1);
        @(negedge clk);
        chk("lu_release", {stall, in_ready}, 2'b01);
        push(64'h101, 5'd6, 1'b1);
        tick();
        chk("lu_accepted", stage_valid, 4'b0101);
        idle();
        repeat (4) tick();

        // Forwarding priority and x0
        alu(64'h200, 5'd7, '0, '0);
        alu(64'h201, 5'd7, '0, '0);
        alu(64'h202, 5'd8, '0, 5'd7);
        chk("fwd_youngest", {fwd_a_sel, fwd_b_sel}, {2'd0, 2'd1});
        alu(64'h203, 5'd0, '0, '0);
        alu(64'h204, 5'd10, 5'd8, 5'd0);
        chk("fwd_x0_and_k2", {fwd_a_sel, fwd_b_sel}, {2'd2, 2'd0});
        idle();
        repeat (4) tick();

        // Flush together with a stall condition on a full chain
        alu(64'h300, 5'd1, '0, '0);
        alu(64'h301, 5'd2, '0, '0);
        alu(64'h302, 5'd3, '0, '0);
        drive(1'b1, 64'h303, 5'd4, '0, '0, 1'b1, 1'b1);
        tick();
        drive(1'b1, 64'h304, 5'd9, 5'd4, '0, 1'b1, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        chk("fl_stall_comb", {stall, in_ready}, 2'b10);
        tick();
        flush = 1'b0;
        idle();
        chk("fl_stage_valid", stage_valid, 4'b1100);
        chk("fl_counts", {stall_count, flush_count}, {16'd1, 16'd1});
        repeat (4) tick();

        // Halt dominates flush; nothing lost
        alu(64'h400, 5'd11, '0, '0);
        alu(64'h401, 5'd12, '0, '0);
        alu(64'h402, 5'd13, '0, '0);
        drive(1'b1, 64'h403, 5'd14, '0, '0, 1'b1, 1'b0);
        halt = 1'b1; flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("halt_in_ready", in_ready, 0);
            tick();
            chk("halt_frozen", {stage_valid, stall_count, flush_count}, {4'b0111, 16'd1, 16'd1});
        end
        halt = 1'b0; flush = 1'b0;
        push(64'h403, 5'd14, 1'b1);
        tick();
        chk("halt_resume", stage_valid, 4'b1111);
        idle();
        repeat (4) tick();

        // Reset with a full chain under halt
        drive(1'b1, 64'h500, 5'd15, '0, '0, 1'b1, 1'b0);
        push(64'h500, 5'd15, 1'b1);
        tick();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 64'(32'h500 + i), 5'(15 + i), '0, '0, 1'b1, 1'b0);
            tick();
        end
        chk("pre_rst_full", stage_valid, 4'b1111);
        halt = 1'b1; reset = 1'b0;
        idle();
        @(negedge clk);
        chk("rst_in_ready_low", in_ready, 0);
        tick();
        chk("mrst_out", {out_valid, out_payload, out_rd, out_regwrite}, '0);
        chk("mrst_stage_fwd", {stage_valid, fwd_a_sel, fwd_b_sel}, '0);
        chk("mrst_counters", {stall_count, flush_count}, '0);
        reset = 1'b1; halt = 1'b0;

        // Counter saturation on the narrow instance
        s_reset = 1'b1;
        repeat (20) tick();
        chk("sat_mid", s_stall_count, 8'd10);
        repeat (580) tick();
        chk("sat_hold", s_stall_count, 8'hFF);
        chk("sat_flush_zero", s_flush_count, 8'd0);

        repeat (3) tick();
        chk("sb_empty", 64'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_chain.md
PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 Parameter STAGES, default 4, number of pipeline register stages (index 0 youngest, STAGES-1 oldest); legal range 2..8.
REQ-002 Parameter PAYLOAD_W, default 64, width of opaque per-instruction payload.
REQ-003 Parameter RF_ADDRESS, default 5, register-index width.
REQ-004 Parameter CNT_W, default 16, width of event counters.
REQ-005 Local FWD_W = $clog2(STAGES); forward-select width.
REQ-006 One clock, clk; reset is synchronous and active-low, port name reset (0 = reset, sampled on posedge clk only).
REQ-007 Ports, in order: clk in 1 clock; reset in 1 sync active-low reset; in_valid in 1 upstream entry present; in_payload in PAYLOAD_W; in_rd in RF_ADDRESS; in_rs1 in RF_ADDRESS; in_rs2 in RF_ADDRESS; in_regwrite in 1; in_memread in 1 load flag; flush in 1 kill young entries; halt in 1 freeze chain; in_ready out 1 entry accepted this cycle; stall out 1 load-use stall; out_valid out 1; out_payload out PAYLOAD_W; out_rd out RF_ADDRESS; out_regwrite out 1; fwd_a_sel out FWD_W; fwd_b_sel out FWD_W; stage_valid out STAGES per-stage valid; stall_count out CNT_W; flush_count out CNT_W.

Function
REQ-008 Each stage SHALL hold valid, payload, rd, rs1, rs2, regwrite, memread; a bubble SHALL have valid=0 and all other fields 0.
REQ-009 Stall SHALL be combinational: stall=1 iff in_valid, stage0 valid, stage0 memread, stage0 regwrite, stage0 rd!=0, and (in_rs1==stage0 rd or in_rs2==stage0 rd).
REQ-010 in_ready SHALL equal ~stall & ~halt & ~flush & reset.
REQ-011 Edge priority, highest first: reset, halt, flush, stall, normal advance.
REQ-012 Halt=1: every stage and both counters SHALL hold; flush and stall ignored that cycle.
REQ-013 Normal advance: stage k takes stage k-1 for k>=1; stage0 takes input if in_valid & in_ready, else bubble.
REQ-014 Stall (no halt/flush): stages 1..STAGES-1 advance; stage0 loads bubble; input not consumed (upstream holds it).
REQ-015 Flush (no halt): stage0 loads bubble, incoming entry dropped, stages 1..STAGES-1 advance (stage1 receives bubble, old stage0 killed).
REQ-016 Latency: entry accepted at edge t appears on out_* after edge t+STAGES-1 (visible STAGES cycles after acceptance cycle) absent halt/flush.
REQ-017 out_* SHALL be stage STAGES-1 fields directly (registered); out_regwrite gated by out_valid.
REQ-018 fwd_a_sel: for stage0 rs1, smallest k in 1..STAGES-1 with stage k valid, regwrite, rd!=0, rd==stage0 rs1; value k; 0 if none or stage0 invalid. fwd_b_sel identical for rs2.
REQ-019 stage_valid[k] SHALL equal stage k valid.
REQ-020 stall_count increments on each edge where stall=1 and halt=0 and flush=0; flush_count increments on each edge where flush=1 and halt=0; both saturate at 2^CNT_W-1.
REQ-021 x0 never causes stall or forwarding.

Reset
REQ-022 reset=0 at edge: all stages bubbles, counters 0; afterwards out_valid=0, out_payload=0, out_rd=0, out_regwrite=0, stage_valid=0, fwd_*_sel=0.
REQ-023 Reset mid-operation discards all in-flight entries regardless of halt/flush.
REQ-024 While reset=0, in_ready=0; stall still reflects combinational inputs but has no effect.

Verification (STAGES=4, PAYLOAD_W=64, CNT_W=16)
REQ-025 Stream payloads 1..8 back-to-back, no hazards -> payload 1 on out after 4th edge post-acceptance, then 2..8 consecutively, in_ready constant 1.
REQ-026 Load rd=5 accepted, next in_rs1=5 -> stall=1 one cycle, in_ready=0, stage_valid=4'b0010 after edge, dependent accepted next cycle, stall_count=1.
REQ-027 ALU rd=7 then rd=7 then consumer rs2=7 -> when consumer in stage0, fwd_b_sel=1 (youngest producer), not 2; rd=0 producer -> fwd_b_sel=0.
REQ-028 Chain full, flush=1 together with stall condition -> stages0/1 bubble next, older two advance, flush_count=1, stall_count unchanged.
REQ-029 halt=1 for 3 cycles with flush=1 -> stage contents and counters frozen, no entry lost; resume continues exactly.
REQ-030 reset=0 with 4 valid entries and halt=1 -> all outputs 0 after edge; 65536 stalls -> stall_count holds 16'hFFFF.
